// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and helpers for the iterative multiply/divide unit.
//   md_op_t    : operation select, RV32M funct3 encoding
//   md_state_t : control FSM states
//   is_signed_a / is_signed_b / is_div / is_rem : operation decode helpers
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } md_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } md_state_t;

    function automatic logic is_signed_a(input md_op_t op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(input md_op_t op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_div(input md_op_t op);
        return op[2];
    endfunction

    function automatic logic is_rem(input md_op_t op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/muldiv_operand_prep.sv
// muldiv_operand_prep: combinational operand conditioning for muldiv_unit.
// Extracts operand signs, forms unsigned magnitudes and detects the cases
// that bypass the iterative datapath, supplying their final quotient and
// remainder directly.
// Optional feature macro: MULDIV_EARLY_OUT_EN (division with
// |dividend| < |divisor| resolves immediately).
// Ports:
//   op          in   operation
//   src_a/src_b in   raw operands
//   sign_a/b    out  operand is negative (always 0 for unsigned sides)
//   mag_a/b     out  two's-complement magnitude
//   special     out  result known without iterating
//   spec_quot   out  quotient to use when special
//   spec_rem    out  remainder to use when special
module muldiv_operand_prep
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  md_op_t                  op,
    input  logic [DATA_WIDTH-1:0]   src_a,
    input  logic [DATA_WIDTH-1:0]   src_b,
    output logic                    sign_a,
    output logic                    sign_b,
    output logic [DATA_WIDTH-1:0]   mag_a,
    output logic [DATA_WIDTH-1:0]   mag_b,
    output logic                    special,
    output logic [DATA_WIDTH-1:0]   spec_quot,
    output logic [DATA_WIDTH-1:0]   spec_rem
);

    localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic div_zero;
    logic overflow;
    logic early;

    always_comb begin
        sign_a   = is_signed_a(op) & src_a[DATA_WIDTH-1];
        sign_b   = is_signed_b(op) & src_b[DATA_WIDTH-1];
        // Magnitude of the most-negative value wraps to itself, which is
        // still the correct unsigned magnitude.
        mag_a    = sign_a ? (~src_a + 1'b1) : src_a;
        mag_b    = sign_b ? (~src_b + 1'b1) : src_b;
        div_zero = is_div(op) && (src_b == '0);
        overflow = ((op == OP_DIV) || (op == OP_REM)) &&
                   (src_a == MOST_NEG) && (&src_b);
`ifdef MULDIV_EARLY_OUT_EN
        early    = is_div(op) && !div_zero && (mag_a < mag_b);
`else
        early    = 1'b0;
`endif
        special  = div_zero | overflow | early;

        spec_quot = '0;
        spec_rem  = src_a;
        if (div_zero) begin
            spec_quot = '1;
            spec_rem  = src_a;
        end else if (overflow) begin
            spec_quot = src_a;
            spec_rem  = '0;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit (MUL/MULH/MULHSU/MULHU/
// DIV/DIVU/REM/REMU) with a start/busy/done handshake. Shift-add multiply
// and restoring divide on magnitudes, one bit per cycle, sign fixed up at
// the end. Optional feature macro: MULDIV_EARLY_OUT_EN (see
// muldiv_operand_prep).
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   Start      request, accepted when Start && !Busy && !Flush
//   Flush      abort the operation in flight, no Done
//   MDControl  operation (funct3 encoding)
//   SrcA/SrcB  operands, sampled on accept
//   Result     registered result, held until the next Done
//   Busy       high in CALC and FIX
//   Done       one-cycle pulse with Result valid
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int MD_CTRL_WIDTH = 3,
    parameter int CNT_WIDTH     = $clog2(DATA_WIDTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     Start,
    input  logic                     Flush,
    input  logic [MD_CTRL_WIDTH-1:0] MDControl,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    output logic [DATA_WIDTH-1:0]    Result,
    output logic                     Busy,
    output logic                     Done
);

    localparam int W = DATA_WIDTH;

    md_state_t            state;
    logic [CNT_WIDTH-1:0] cnt;

    // Datapath: hi/lo hold product (multiply) or remainder/quotient (divide).
    md_op_t               op_r;
    logic [W-1:0]         hi;
    logic [W-1:0]         lo;
    logic [W-1:0]         addend;
    logic                 neg;

    md_op_t               op_in;
    logic                 sign_a, sign_b, special;
    logic [W-1:0]         mag_a, mag_b, spec_quot, spec_rem;
    logic                 accept;

    assign op_in  = md_op_t'(MDControl);
    assign accept = Start && !Busy && !Flush;

    muldiv_operand_prep #(.DATA_WIDTH(W)) u_prep (
        .op        (op_in),
        .src_a     (SrcA),
        .src_b     (SrcB),
        .sign_a    (sign_a),
        .sign_b    (sign_b),
        .mag_a     (mag_a),
        .mag_b     (mag_b),
        .special   (special),
        .spec_quot (spec_quot),
        .spec_rem  (spec_rem)
    );

    function automatic logic [2*W-1:0] cond_neg_2w(input logic [2*W-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [W-1:0] cond_neg_w(input logic [W-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    // Iteration step
    logic [W:0]     mul_sum;
    logic [W:0]     div_shift;
    logic [W-1:0]   div_diff;
    logic           div_ge;
    logic [2*W-1:0] prod_s;
    logic [W-1:0]   fix_res;

    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, addend} : '0);
        div_shift = {hi, lo[W-1]};
        div_ge    = div_shift >= {1'b0, addend};
        // When div_ge holds the true difference is below 2^W, so W bits suffice.
        div_diff  = div_shift[W-1:0] - addend;

        prod_s = cond_neg_2w({hi, lo}, neg);
        case (op_r)
            OP_MUL:                        fix_res = prod_s[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fix_res = prod_s[2*W-1:W];
            OP_DIV, OP_DIVU:               fix_res = cond_neg_w(lo, neg);
            default:                       fix_res = cond_neg_w(hi, neg);
        endcase
    end

    // Datapath registers: loaded on accept, stepped in CALC
    always_ff @(posedge clk) begin
        if (accept) begin
            op_r <= op_in;
            if (special) begin
                hi     <= spec_rem;
                lo     <= spec_quot;
                addend <= mag_b;
                neg    <= 1'b0;
            end else if (is_div(op_in)) begin
                hi     <= '0;
                lo     <= mag_a;
                addend <= mag_b;
                neg    <= is_rem(op_in) ? sign_a : (sign_a ^ sign_b);
            end else begin
                hi     <= '0;
                lo     <= mag_b;
                addend <= mag_a;
                neg    <= sign_a ^ sign_b;
            end
        end else if (state == S_CALC) begin
            if (is_div(op_r)) begin
                hi <= div_ge ? div_diff : div_shift[W-1:0];
                lo <= {lo[W-2:0], div_ge};
            end else begin
                hi <= mul_sum[W:1];
                lo <= {mul_sum[0], lo[W-1:1]};
            end
        end
    end

    // Control FSM and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            Result <= '0;
            Busy   <= 1'b0;
            Done   <= 1'b0;
        end else if (Flush) begin
            state <= S_IDLE;
            cnt   <= '0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
        end else begin
            case (state)
                S_CALC: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_WIDTH'(1)) state <= S_FIX;
                end
                S_FIX: begin
                    state  <= S_DONE;
                    Result <= fix_res;
                    Busy   <= 1'b0;
                    Done   <= 1'b1;
                end
                default: begin
                    Done <= 1'b0;
                    if (Start) begin
                        Busy <= 1'b1;
                        if (special) begin
                            state <= S_FIX;
                        end else begin
                            state <= S_CALC;
                            cnt   <= CNT_WIDTH'(W);
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed-vector bench for muldiv_unit (W=32).
module tb_muldiv_unit;

    localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
    localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        Start = 1'b0;
    logic        Flush = 1'b0;
    logic [2:0]  MDControl = '0;
    logic [31:0] SrcA = '0;
    logic [31:0] SrcB = '0;
    logic [31:0] Result;
    logic        Busy;
    logic        Done;

    int n_cmp = 0;
    int n_bad = 0;

    muldiv_unit dut (
        .clk       (clk),
        .rst       (rst),
        .Start     (Start),
        .Flush     (Flush),
        .MDControl (MDControl),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .Result    (Result),
        .Busy      (Busy),
        .Done      (Done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Watch from cycle `first` on for Done (bounded); counts cycles in which
    // Busy disagrees with "high until the Done cycle".
    task automatic wait_done(input int first, output logic [31:0] res,
                             output int lat, output int busy_bad);
        lat = -1;
        busy_bad = 0;
        res = '0;
        for (int n = first; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (Done) begin
                lat = n;
                res = Result;
                if (Busy) busy_bad++;
                break;
            end
            if (!Busy) busy_bad++;
        end
    endtask

    // Called at #1 after an edge; the op is accepted on the next edge (edge 0).
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int busy_bad);
        MDControl = op;
        SrcA = a;
        SrcB = b;
        Start = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        // Cycle 1 already running: Busy must be high here.
        busy_bad = Busy ? 0 : 1;
        if (Done) begin
            lat = 1;
            res = Result;
        end else begin
            int bb;
            wait_done(2, res, lat, bb);
            busy_bad += bb;
        end
    endtask

    typedef struct {
        string       tag;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [31:0] res, prev;
        int lat, bb, dones;

        repeat (2) @(posedge clk);
        #1;
        check_val("rst_result", Result, 32'h0);
        check_val("rst_busy", {31'b0, Busy}, 32'h0);
        check_val("rst_done", {31'b0, Done}, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // MUL with full timing checks
        do_op(MUL, 32'd7, 32'hFFFF_FFFD, res, lat, bb);
        check_val("mul_res", res, 32'hFFFF_FFEB);
        check_val("mul_lat", lat, 32'd34);
        check_val("mul_busy", bb, 32'd0);

        vecs.push_back('{"mulh",    MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34});
        vecs.push_back('{"mulhu",   MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34});
        vecs.push_back('{"mulhsu",  MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34});
        vecs.push_back('{"div",     DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34});
        vecs.push_back('{"rem",     REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34});
        vecs.push_back('{"divu",    DIVU,   32'd7,         32'd2,         32'd3,         34});
        vecs.push_back('{"remu",    REMU,   32'd7,         32'd2,         32'd1,         34});
        vecs.push_back('{"div0",    DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 2});
        vecs.push_back('{"rem0",    REM,    32'd5,         32'd0,         32'd5,         2});
        vecs.push_back('{"div_ovf", DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2});
        vecs.push_back('{"rem_ovf", REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         2});
        vecs.push_back('{"mul_big", MUL,    32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 34});
`ifdef MULDIV_EARLY_OUT_EN
        vecs.push_back('{"divu_eo", DIVU,   32'd3,         32'd10,        32'd0,         2});
        vecs.push_back('{"rem_eo",  REM,    32'hFFFF_FFFD, 32'd10,        32'hFFFF_FFFD, 2});
`else
        vecs.push_back('{"divu_eo", DIVU,   32'd3,         32'd10,        32'd0,         34});
        vecs.push_back('{"rem_eo",  REM,    32'hFFFF_FFFD, 32'd10,        32'hFFFF_FFFD, 34});
`endif

        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, bb);
            check_val({vecs[i].tag, "_res"}, res, vecs[i].exp);
            check_val({vecs[i].tag, "_lat"}, lat, vecs[i].lat);
        end

        // Start asserted in cycle 5 of a MUL is ignored.
        MDControl = MUL; SrcA = 32'd7; SrcB = 32'hFFFF_FFFD; Start = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        MDControl = DIVU; SrcA = 32'd100; SrcB = 32'd3; Start = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        wait_done(7, res, lat, bb);
        check_val("ign_res", res, 32'hFFFF_FFEB);
        check_val("ign_lat", lat, 32'd34);

        // Flush in cycle 10: Busy drops from cycle 11, no Done, Result kept.
        @(posedge clk);
        #1;
        prev = Result;
        MDControl = MUL; SrcA = 32'h0000_1234; SrcB = 32'h10; Start = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        Flush = 1'b1;
        @(posedge clk);
        #1;
        Flush = 1'b0;
        check_val("flush_busy", {31'b0, Busy}, 32'h0);
        dones = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (Done) dones++;
        end
        check_val("flush_nodone", dones, 32'd0);
        check_val("flush_result", Result, prev);

        // Flush and Start together: start dropped.
        MDControl = MUL; SrcA = 32'd2; SrcB = 32'd3; Start = 1'b1; Flush = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0; Flush = 1'b0;
        check_val("flush_start_busy", {31'b0, Busy}, 32'h0);

        // Back-to-back: new Start during the DONE cycle.
        do_op(DIVU, 32'd7, 32'd2, res, lat, bb);
        check_val("b2b_first_res", res, 32'd3);
        do_op(REMU, 32'd7, 32'd2, res, lat, bb);
        check_val("b2b_second_res", res, 32'd1);
        check_val("b2b_second_lat", lat, 32'd34);

        // Asynchronous reset mid-operation.
        MDControl = MUL; SrcA = 32'd9; SrcB = 32'd9; Start = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_val("midrst_busy", {31'b0, Busy}, 32'h0);
        check_val("midrst_result", Result, 32'h0);
        check_val("midrst_done", {31'b0, Done}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative, parametrised multiply/divide unit implementing the full RV32M operation set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for the execute stage, beside `alu`. It takes operands through a start/busy/done handshake. It computes in a fixed number of cycles using a shift-add multiplier or a restoring divider. The pipeline stalls on `Busy`, and the result is read back when `Done` pulses.

## Interface
- `DATA_WIDTH`, 32, operand/result width W (≥ 8)
- `MD_CTRL_WIDTH`, 3, operation select width
- `CNT_WIDTH`, $clog2(DATA_WIDTH)+1, iteration counter width
- One clock; reset is asynchronous and active-high.
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous active-high reset
- `Start`  in  1  request; accepted when `Start && !Busy && !Flush`
- `Flush`  in  1  abort current operation (pipeline flush)
- `MDControl`  in  3  operation, funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `SrcA`  in  W  multiplicand / dividend, sampled on accept
- `SrcB`  in  W  multiplier / divisor, sampled on accept
- `Result`  out  W  registered result, held until the next `Done`
- `Busy`  out  1  operation in flight
- `Done`  out  1  one-cycle pulse, `Result` valid this cycle

## Operation
- States: IDLE, CALC, FIX, DONE.
- Reset values: IDLE; `Result`=0, `Busy`=0, `Done`=0, counter=0.
- **IDLE/DONE + accept:** latch the op, the operand magnitudes and the operand signs.
  - Signedness: SrcA is signed for MUL/MULH/MULHSU/DIV/REM. SrcB is signed for MUL/MULH/DIV/REM.
  - Normal case: go to CALC with counter = W.
  - Special case: go straight to FIX.
- **CALC:** one iteration per cycle, counter decrements, and the state exits to FIX when the counter reaches 1.
  - Multiply: 2W-bit shift-add on magnitudes.
  - Divide: restoring, one quotient bit per cycle, W-bit partial remainder plus a carry bit.
- **FIX:** negate the result per sign rules, select the low or high half, and register it into `Result`. Next state is DONE.
- **DONE:** `Done`=1 and `Busy`=0. Next state is IDLE, or CALC/FIX if a new `Start` is accepted in this cycle (back-to-back).
- **Sign rules:**
  - Product sign = sA^sB, with unsigned sides treated as positive.
  - Quotient sign = sA^sB (DIV only).
  - Remainder sign = sA (REM only).
- **Special cases** (RISC-V semantics, no traps):
  - Divisor 0: quotient all-ones, remainder = SrcA.
  - Signed overflow (most-negative / −1): quotient = SrcA, remainder 0.
- **Flush:**
  - In any state, the next state is IDLE. No `Done` is produced and `Result` is unchanged.
  - `Flush` with `Start` in the same cycle: the flush wins and the start is dropped.
- **Start while Busy:** ignored, with no effect on the operation in flight.
- **Reset mid-operation:** immediate return to the reset values. No `Done`.

## Timing
- Accept at edge 0. Normal op: CALC occupies cycles 1..W, FIX is cycle W+1, and `Done` is high in cycle W+2 (34 for W=32).
- Special case (and early-out, see Configuration): FIX in cycle 1, `Done` in cycle 2.
- `Busy` is high exactly in CALC and FIX.
- `Result` changes only on the edge entering DONE.
- No combinational path from inputs to outputs.

## Configuration
- `MULDIV_EARLY_OUT_EN` defined:
  - DIV/DIVU/REM/REMU with |dividend| < |divisor| (nonzero divisor) skip CALC.
  - Quotient is 0 and remainder = SrcA, with 2-cycle latency.
- Not defined: these divisions take the full W+2 cycles. Results are identical either way.

## Structure
- `muldiv_pkg`: op enum (`md_op_t`, funct3 encoding), state enum (`md_state_t`), helper `is_signed_a`/`is_signed_b`/`is_div` functions.
- Sub-module `muldiv_operand_prep` (combinational): per-operand sign extraction, magnitude (two's-complement abs), and special-case/early-out detection.
- The datapath and FSM live in `muldiv_unit`.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3) → `Result`=0xFFFFFFEB, `Done` in cycle 34, `Busy` high cycles 1–33.
- High-half products:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Signed/unsigned division with −7 (0xFFFFFFF9) and 2:
  - DIV → 0xFFFFFFFD.
  - REM → 0xFFFFFFFF.
  - DIVU 7/2 → 3.
  - REMU 7/2 → 1.
- Special cases, each with `Done` in cycle 2:
  - DIV 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- Flush:
  - Start MUL, then `Flush` in cycle 10 → `Busy`=0 from cycle 11, no `Done`, and `Result` keeps the prior value.
  - `Start` asserted in cycle 5 of an op → ignored.
- Back-to-back and early-out:
  - New `Start` in a DONE cycle → next `Done` exactly W+2 cycles later.
  - DIVU 3/10 → 0, in cycle 2 with `MULDIV_EARLY_OUT_EN` and cycle 34 without.
